wave_capture_ctrl: RTL and testbench

Sequencer for the waveform display path: decides when microphone samples enter the 1280-point display sample memory. The line-graph renderer reads that memory to build its waveform overlay. The block arms on a rising level crossing, with an auto-trigger timeout, decimates by the user `level` setting, and writes exactly one full, untorn frame. It then holds before re-arming. A freeze switch locks the displayed frame. Sits between the mic sampling front end and the dual-port sample memory write port; the VGA side owns the read port.

---
 rtl/wave_capture_ctrl.sv | 177 +++++++++++++++++
 tb/tb_wave_capture_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wave_capture_ctrl
// Description : Write sequencer for the waveform display sample memory.
//               Arms on a rising level crossing (or auto-triggers after a
//               timeout), decimates by the user level setting, writes one
//               complete frame, then holds before re-arming. A freeze switch
//               keeps the displayed frame from being overwritten.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_capture_ctrl #(
  parameter int          NUM_POINTS  = 1280,
  parameter logic [11:0] TRIG_LEVEL  = 12'd2048,
  parameter int          ARM_TIMEOUT = 4096,
  parameter int          HOLD_TICKS  = 256
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic [11:0] mic_in,
  input  logic        freeze,
  input  logic        trig_en,
  input  logic [3:0]  level,
  output logic        wr_en,
  output logic [10:0] wr_addr,
  output logic [9:0]  wr_data,
  output logic        frame_done,
  output logic        busy,
  output logic [1:0]  state
);

  // Hold counter is wide enough to hold HOLD_TICKS itself, which marks
  // "terminal count reached, waiting for freeze to drop".
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [10:0]   LAST_ADDR = 11'(NUM_POINTS - 1);
  localparam logic [12:0]   TMO_LAST  = 13'(ARM_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_DONE = HW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t          cur;
  logic [11:0]     prev_sample;
  logic [10:0]     addr_cnt;
  logic [3:0]      dcnt;
  logic [3:0]      lvl_q;
  logic [12:0]     tmo;
  logic [HW-1:0]   hcnt;
  logic            done_pend;
  logic            crossing;
  logic            timed_out;

  // Rising crossing compares the previous tick's sample with the current one
  assign crossing  = (prev_sample < TRIG_LEVEL) && (mic_in >= TRIG_LEVEL);
  assign timed_out = (tmo == TMO_LAST);
  assign state     = cur;

  // Track the signal on every tick in every state so the crossing detector
  // is already primed when ARM is entered.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      prev_sample <= '0;
    end else if (sample_tick) begin
      prev_sample <= mic_in;
    end
  end

  // Capture sequencer with registered memory-port and status outputs
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= S_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      done_pend  <= 1'b0;
      busy       <= 1'b0;
      addr_cnt   <= '0;
      dcnt       <= '0;
      lvl_q      <= '0;
      tmo        <= '0;
      hcnt       <= '0;
    end else begin
      wr_en      <= 1'b0;
      done_pend  <= 1'b0;
      // frame_done trails the final write strobe by one cycle
      frame_done <= done_pend;

      unique case (cur)
        S_IDLE: begin
          if (!freeze) begin
            cur <= S_ARM;
            tmo <= '0;
          end
        end

        S_ARM: begin
          if (!trig_en) begin
            // Free-run: preload dcnt so the first CAPTURE tick writes
            cur      <= S_CAPTURE;
            busy     <= 1'b1;
            lvl_q    <= level;
            dcnt     <= level;
            addr_cnt <= '0;
          end else if (sample_tick) begin
            if (crossing || timed_out) begin
              // Trigger sample (real or forced) is the first point of the frame
              cur      <= S_CAPTURE;
              busy     <= 1'b1;
              lvl_q    <= level;
              dcnt     <= '0;
              wr_en    <= 1'b1;
              wr_addr  <= '0;
              wr_data  <= mic_in[11:2];
              addr_cnt <= 11'd1;
            end else begin
              tmo <= tmo + 13'd1;
            end
          end
        end

        S_CAPTURE: begin
          if (sample_tick) begin
            if (dcnt == lvl_q) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_cnt;
              wr_data <= mic_in[11:2];
              dcnt    <= '0;
              if (addr_cnt == LAST_ADDR) begin
                // Frame complete; freeze never cuts a frame short
                cur       <= S_HOLD;
                busy      <= 1'b0;
                addr_cnt  <= '0;
                hcnt      <= '0;
                done_pend <= 1'b1;
              end else begin
                addr_cnt <= addr_cnt + 11'd1;
              end
            end else begin
              dcnt <= dcnt + 4'd1;
            end
          end
        end

        S_HOLD: begin
          wr_addr <= '0;
          if (hcnt == HOLD_DONE) begin
            // Terminal count already reached; leave as soon as freeze drops
            if (!freeze) begin
              cur <= S_ARM;
              tmo <= '0;
            end
          end else if (sample_tick) begin
            if ((hcnt == HOLD_LAST) && !freeze) begin
              cur  <= S_ARM;
              tmo  <= '0;
              hcnt <= '0;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
        end

        default: cur <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wave_capture_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wave_capture_ctrl
// Description : Self-checking bench for wave_capture_ctrl. Writes are logged
//               and compared against frames predicted from the tick stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wave_capture_ctrl;

  localparam int NUM_POINTS = 1280;
  localparam int TRIG       = 2048;
  localparam int ARM_TMO    = 4096;
  localparam int HOLD_T     = 256;

  logic        CLOCK = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [11:0] mic_in = '0;
  logic        freeze = 1'b0;
  logic        trig_en = 1'b0;
  logic [3:0]  level = '0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [9:0]  wr_data;
  logic        frame_done;
  logic        busy;
  logic [1:0]  state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // tick log (value, edge number) and observed write / frame_done log
  int tk_v[$], tk_e[$];
  int got_a[$], got_d[$], got_e[$], fd_e[$];
  int exp_a[$], exp_d[$], exp_e[$];

  wave_capture_ctrl dut (
    .CLOCK       (CLOCK),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .mic_in      (mic_in),
    .freeze      (freeze),
    .trig_en     (trig_en),
    .level       (level),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .busy        (busy),
    .state       (state)
  );

  always #5 CLOCK = ~CLOCK;

  // Edge counter plus write/frame_done monitor, sampled just after the edge
  always @(posedge CLOCK) begin
    cyc++;
    #1;
    if (wr_en === 1'b1) begin
      got_a.push_back(int'(wr_addr));
      got_d.push_back(int'(wr_data));
      got_e.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_e.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    tk_v.delete(); tk_e.delete();
    got_a.delete(); got_d.delete(); got_e.delete(); fd_e.delete();
  endtask

  task automatic apply_reset(input bit frz, input bit te, input logic [3:0] lv);
    @(negedge CLOCK);
    freeze = frz; trig_en = te; level = lv; sample_tick = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge CLOCK);
    clear_logs();
    rst_n = 1'b1;
  endtask

  // One tick consumed by the next rising edge; returns just after that edge
  task automatic send_tick(input logic [11:0] v);
    @(negedge CLOCK);
    sample_tick = 1'b1; mic_in = v;
    tk_v.push_back(int'(v)); tk_e.push_back(cyc + 1);
    @(posedge CLOCK);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic wait_state(input logic [1:0] st, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK);
      if (state === st) begin ok = 1'b1; break; end
    end
  endtask

  // Reference: counting captured ticks from the frame's first tick s, every
  // (L+1)-th tick is stored at the next address until the frame is full.
  function automatic void build_expected(input int s, input int L);
    exp_a.delete(); exp_d.delete(); exp_e.delete();
    for (int j = 0; s + j < tk_v.size(); j++) begin
      if ((j % (L + 1)) == 0 && (j / (L + 1)) < NUM_POINTS) begin
        exp_a.push_back(j / (L + 1));
        exp_d.push_back(tk_v[s + j] >> 2);
        exp_e.push_back(tk_e[s + j]);
      end
    end
  endfunction

  function automatic int frame_mismatch(output int first);
    int bad;
    bad = 0; first = -1;
    if (got_a.size() != exp_a.size()) bad++;
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i] || got_e[i] != exp_e[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    return bad;
  endfunction

  task automatic test_reset();
    @(negedge CLOCK);
    rst_n = 1'b0; freeze = 1'b1;
    #1;
    n_checks++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state);
    else n_pass++;
    n_checks++;
    if ({wr_en, wr_addr, wr_data, frame_done, busy} !== '0)
      $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%0d fd=%b busy=%b expected all 0",
               wr_en, wr_addr, wr_data, frame_done, busy);
    else n_pass++;
    idle(2);
    clear_logs();
    rst_n = 1'b1;
    idle(5);
    send_tick(12'd3000);
    idle(3);
    n_checks++;
    if (state !== 2'd0 || got_a.size() !== 0)
      $display("FAIL idle_frozen: got state %0d writes %0d expected state 0 writes 0", state, got_a.size());
    else n_pass++;
  endtask

  task automatic test_free_run();
    bit ok; int nbad, first;
    apply_reset(1'b0, 1'b0, 4'd0);
    wait_state(2'd2, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL free_enter_capture: got state %0d expected 2", state);
    else n_pass++;
    for (int j = 0; j < NUM_POINTS; j++) begin
      send_tick(12'((j * 3 + 7) & 12'hFFF));
      if (j == 640) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL free_busy: got %b expected 1", busy);
        else n_pass++;
      end
      idle(3);
    end
    idle(3);
    build_expected(0, 0);
    nbad = frame_mismatch(first);
    n_checks++;
    if (nbad !== 0) $display("FAIL free_frame: %0d bad, first at %0d, writes %0d expected %0d",
                             nbad, first, got_a.size(), exp_a.size());
    else n_pass++;
    n_checks++;
    if (fd_e.size() !== 1 || fd_e[0] !== exp_e[exp_e.size() - 1] + 1)
      $display("FAIL free_frame_done: got %0d pulses expected 1 at edge %0d",
               fd_e.size(), exp_e[exp_e.size() - 1] + 1);
    else n_pass++;
    n_checks++;
    if (state !== 2'd3 || busy !== 1'b0)
      $display("FAIL free_hold: got state %0d busy %b expected state 3 busy 0", state, busy);
    else n_pass++;
    // HOLD lasts exactly HOLD_T ticks
    for (int j = 0; j < HOLD_T - 1; j++) send_tick(12'($urandom_range(0, 4095)));
    n_checks++;
    if (state !== 2'd3) $display("FAIL hold_early: got state %0d expected 3", state);
    else n_pass++;
    send_tick(12'd5);
    n_checks++;
    if (state !== 2'd1 || got_a.size() !== NUM_POINTS)
      $display("FAIL hold_exit: got state %0d writes %0d expected state 1 writes %0d",
               state, got_a.size(), NUM_POINTS);
    else n_pass++;
  endtask

  task automatic test_trigger();
    bit ok;
    apply_reset(1'b1, 1'b1, 4'd0);
    idle(3);
    send_tick(12'd3000);      // seen only by the sample history
    idle(2);
    n_checks++;
    if (state !== 2'd0 || got_a.size() !== 0)
      $display("FAIL trig_idle: got state %0d writes %0d expected 0 0", state, got_a.size());
    else n_pass++;
    freeze = 1'b0;
    wait_state(2'd1, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL trig_arm: got state %0d expected 1", state);
    else n_pass++;
    send_tick(12'd2500);      // previous sample 3000: not a rising crossing
    send_tick(12'd2000);
    send_tick(12'd2040);
    idle(2);
    n_checks++;
    if (got_a.size() !== 0 || state !== 2'd1)
      $display("FAIL trig_no_cross: got writes %0d state %0d expected 0 1", got_a.size(), state);
    else n_pass++;
    send_tick(12'd2050);
    idle(1);
    n_checks++;
    if (got_a.size() !== 1) $display("FAIL trig_write_count: got %0d expected 1", got_a.size());
    else if (got_a[0] !== 0 || got_d[0] !== 512 || got_e[0] !== tk_e[tk_e.size() - 1])
      $display("FAIL trig_write: got addr %0d data %0d edge %0d expected 0 512 %0d",
               got_a[0], got_d[0], got_e[0], tk_e[tk_e.size() - 1]);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || state !== 2'd2)
      $display("FAIL trig_busy: got busy %b state %0d expected 1 2", busy, state);
    else n_pass++;
  endtask

  // Random data, back-to-back ticks, random decimation, triggered start
  task automatic test_back_to_back();
    bit ok; int L, n, s, prev, nbad, first;
    L = $urandom_range(0, 2);
    apply_reset(1'b0, 1'b1, 4'(L));
    wait_state(2'd1, ok);
    n_checks++;
    if (ok !== 1'b1) $display("FAIL b2b_arm: got state %0d expected 1", state);
    else n_pass++;
    n = (NUM_POINTS - 1) * (L + 1) + 1 + 64;
    for (int j = 0; j < n; j++) send_tick(12'($urandom_range(0, 4095)));
    idle(3);
    s = -1; prev = 0;
    for (int i = 0; i < tk_v.size(); i++) begin
      if ((prev < TRIG && tk_v[i] >= TRIG) || i == ARM_TMO - 1) begin s = i; break; end
      prev = tk_v[i];
    end
    build_expected(s, L);
    nbad = frame_mismatch(first);
    n_checks++;
    if (nbad !== 0) $display("FAIL b2b_frame: L=%0d start %0d, %0d bad, first at %0d, writes %0d expected %0d",
                             L, s, nbad, first, got_a.size(), exp_a.size());
    else n_pass++;
    n_checks++;
    if (fd_e.size() !== 1 || fd_e[0] !== exp_e[exp_e.size() - 1] + 1 || state !== 2'd3)
      $display("FAIL b2b_done: got %0d pulses state %0d expected 1 pulse at %0d state 3",
               fd_e.size(), state, exp_e[exp_e.size() - 1] + 1);
    else n_pass++;
  endtask

  task automatic test_timeout(input logic [11:0] last_v);
    bit ok;
    apply_reset(1'b0, 1'b1, 4'd0);
    wait_state(2'd1, ok);
    for (int j = 0; j < ARM_TMO - 1; j++) send_tick(12'd100);
    idle(1);
    n_checks++;
    if (ok !== 1'b1 || got_a.size() !== 0 || state !== 2'd1)
      $display("FAIL tmo_wait: got writes %0d state %0d expected 0 1", got_a.size(), state);
    else n_pass++;
    send_tick(last_v);
    idle(1);
    n_checks++;
    if (got_a.size() !== 1) $display("FAIL tmo_write_count: got %0d expected 1", got_a.size());
    else if (got_a[0] !== 0 || got_d[0] !== int'(last_v >> 2) || state !== 2'd2)
      $display("FAIL tmo_write: got addr %0d data %0d state %0d expected 0 %0d 2",
               got_a[0], got_d[0], state, last_v >> 2);
    else n_pass++;
  endtask

  task automatic test_decimation();
    bit ok; int nbad, first;
    apply_reset(1'b0, 1'b0, 4'd3);
    wait_state(2'd2, ok);
    for (int j = 0; j < (NUM_POINTS - 1) * 4 + 1; j++) begin
      if (j == 100) level = 4'd0;
      send_tick(12'($urandom_range(0, 4095)));
    end
    idle(3);
    build_expected(0, 3);
    nbad = frame_mismatch(first);
    n_checks++;
    if (ok !== 1'b1 || nbad !== 0)
      $display("FAIL decim_frame: %0d bad, first at %0d, writes %0d expected %0d",
               nbad, first, got_a.size(), exp_a.size());
    else n_pass++;
    n_checks++;
    if (fd_e.size() !== 1 || state !== 2'd3)
      $display("FAIL decim_done: got %0d pulses state %0d expected 1 3", fd_e.size(), state);
    else n_pass++;
  endtask

  task automatic test_freeze();
    bit ok; int nbad, first;
    apply_reset(1'b0, 1'b0, 4'd0);
    wait_state(2'd2, ok);
    for (int j = 0; j < NUM_POINTS; j++) begin
      send_tick(12'($urandom_range(0, 4095)));
      idle(1);
      if (j == 600) freeze = 1'b1;
    end
    idle(3);
    build_expected(0, 0);
    nbad = frame_mismatch(first);
    n_checks++;
    if (ok !== 1'b1 || nbad !== 0 || state !== 2'd3)
      $display("FAIL freeze_frame: %0d bad, first at %0d, writes %0d state %0d expected %0d writes state 3",
               nbad, first, got_a.size(), state, exp_a.size());
    else n_pass++;
    for (int j = 0; j < 400; j++) send_tick(12'($urandom_range(0, 4095)));
    idle(5);
    n_checks++;
    if (state !== 2'd3 || got_a.size() !== NUM_POINTS)
      $display("FAIL freeze_hold: got state %0d writes %0d expected 3 %0d", state, got_a.size(), NUM_POINTS);
    else n_pass++;
    @(negedge CLOCK);
    freeze = 1'b0;
    @(posedge CLOCK);
    #1;
    n_checks++;
    if (state !== 2'd1) $display("FAIL freeze_release: got state %0d expected 1", state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_capture();
    bit ok; int nbad, first;
    apply_reset(1'b0, 1'b0, 4'd0);
    wait_state(2'd2, ok);
    for (int j = 0; j <= 700; j++) send_tick(12'($urandom_range(0, 4095)));
    #2;
    n_checks++;
    if (got_a.size() !== 701 || wr_en !== 1'b1)
      $display("FAIL midrst_pre: got writes %0d wr_en %b expected 701 1", got_a.size(), wr_en);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state, wr_en, wr_addr, wr_data, frame_done, busy} !== '0)
      $display("FAIL midrst_async: got state %0d wr_en %b addr %0d data %0d fd %b busy %b expected all 0",
               state, wr_en, wr_addr, wr_data, frame_done, busy);
    else n_pass++;
    idle(2);
    clear_logs();
    rst_n = 1'b1;
    wait_state(2'd2, ok);
    for (int j = 0; j < 8; j++) send_tick(12'($urandom_range(0, 4095)));
    idle(2);
    build_expected(0, 0);
    nbad = frame_mismatch(first);
    n_checks++;
    if (ok !== 1'b1 || nbad !== 0 || got_a.size() !== 8)
      $display("FAIL midrst_restart: %0d bad, first at %0d, writes %0d expected 8 from address 0",
               nbad, first, got_a.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_trigger();
    test_back_to_back();
    test_timeout(12'd100);
    test_timeout(12'd3000);
    test_decimation();
    test_freeze();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
